// File: rtl/matrix_codec_pkg.sv
// Shared dimensions, rho offsets, inverse-pi lane index and FSM states for
// the matrix codec. Slice bit 5*y+x holds lane (x,y); slice index is depth z.
package matrix_codec_pkg;

  localparam int unsigned LANES   = 25;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned SLICE_W = 25;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned CNT_W   = ADDR_W + 1;

  // Rho rotation per lane, indexed by 5*y+x.
  localparam logic [ADDR_W-1:0] RHO [LANES] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  // Full encoded state: DEPTH slices of SLICE_W bits.
  typedef logic [DEPTH-1:0][SLICE_W-1:0] state_buf_t;

  // Encoded slice bit that feeds decoded lane (x,y): lane (y, (2x+3y) mod 5).
  function automatic int inv_pi_src(input int x, input int y);
    return 5 * ((2 * x + 3 * y) % 5) + y;
  endfunction

endpackage

// File: rtl/matrix_decoder_if.sv
// Memory-side bus of the matrix decoder.
//   start        block request (level)
//   read_addr    encoded line memory address; line_in returns one cycle later
//   write_*      decoded slice write port
//   done         block complete (level)
// slave = decoder, master = surrounding memory/controller.
interface matrix_decoder_if;
  import matrix_codec_pkg::*;

  logic                start;
  logic [ADDR_W-1:0]   read_addr;
  logic [SLICE_W-1:0]  line_in;
  logic                write_enable;
  logic [ADDR_W-1:0]   write_addr;
  logic [SLICE_W-1:0]  write_value;
  logic                done;

  modport master (
    output start, line_in,
    input  read_addr, write_enable, write_addr, write_value, done
  );

  modport slave (
    input  start, line_in,
    output read_addr, write_enable, write_addr, write_value, done
  );
endinterface

// File: rtl/slice_gather.sv
// Combinational decode of one slice: undoes pi and rho for depth z.
//   state_buf  in  1600-bit encoded state
//   z          in  decoded slice index
//   slice      out decoded slice z
module slice_gather
  import matrix_codec_pkg::*;
(
  input  state_buf_t          state_buf,
  input  logic [ADDR_W-1:0]   z,
  output logic [SLICE_W-1:0]  slice
);

  // One 64:1 mux per lane; source lane and rotation are constants.
  for (genvar y = 0; y < 5; y++) begin : g_y
    for (genvar x = 0; x < 5; x++) begin : g_x
      localparam int SRC = inv_pi_src(x, y);
      logic [ADDR_W-1:0] zz;
      // 6-bit add wraps mod 64.
      assign zz = z + RHO[5*y+x];
      assign slice[5*y+x] = state_buf[zz][SRC];
    end
  end

endmodule

// File: rtl/matrix_decoder.sv
// Matrix block decoder: loads 64 encoded slices, then writes 64 decoded
// slices, framed by start/done.
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset
//   bus   slave port of matrix_decoder_if (read, write and framing signals)
module matrix_decoder
  import matrix_codec_pkg::*;
(
  input logic              clk,
  input logic              rst,
  matrix_decoder_if.slave  bus
);

  state_t             state;
  logic [CNT_W-1:0]   load_cnt;
  state_buf_t         state_buf;
  logic [SLICE_W-1:0] gathered;

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      load_cnt         <= '0;
      bus.read_addr    <= '0;
      bus.write_enable <= 1'b0;
      bus.write_addr   <= '0;
      bus.done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state         <= LOAD;
            load_cnt      <= '0;
            bus.read_addr <= '0;
          end
        end
        LOAD: begin
          // load_cnt = cycles since entry; capture trails the address by two.
          load_cnt <= load_cnt + CNT_W'(1);
          if (load_cnt < CNT_W'(DEPTH - 1)) begin
            bus.read_addr <= ADDR_W'(load_cnt + CNT_W'(1));
          end
          if (load_cnt == CNT_W'(DEPTH)) begin
            state            <= WRITE;
            load_cnt         <= '0;
            bus.read_addr    <= '0;
            bus.write_enable <= 1'b1;
            bus.write_addr   <= '0;
          end
        end
        WRITE: begin
          if (bus.write_addr == ADDR_W'(DEPTH - 1)) begin
            state            <= DONE;
            bus.write_enable <= 1'b0;
            bus.write_addr   <= '0;
            bus.done         <= 1'b1;
          end else begin
            bus.write_addr <= bus.write_addr + ADDR_W'(1);
          end
        end
        DONE: begin
          // Wait for start to drop so a held start cannot re-trigger.
          if (!bus.start) begin
            state    <= IDLE;
            bus.done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slice buffer; contents are don't-care until a full load completes.
  always_ff @(posedge clk) begin
    if (state == LOAD && load_cnt != '0) begin
      state_buf[ADDR_W'(load_cnt - CNT_W'(1))] <= bus.line_in;
    end
  end

  slice_gather u_gather (
    .state_buf (state_buf),
    .z         (bus.write_addr),
    .slice     (gathered)
  );

  // Gate so write_value reads zero whenever no write is in progress.
  assign bus.write_value = bus.write_enable ? gathered : '0;

endmodule

// File: tb/tb_matrix_decoder.sv
// Self-checking bench for matrix_decoder: line memory model, scoreboard of
// expected writes, table-driven single-bit vectors, random encoded blocks,
// mid-write reset and held-start sequences.
module tb_matrix_decoder;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  matrix_decoder_if bus ();

  matrix_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Encoded line memory with one cycle of read latency.
  logic [24:0] mem [64];
  always @(posedge clk) bus.line_in <= mem[bus.read_addr];

  typedef struct packed {
    logic [5:0]  addr;
    logic [24:0] value;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          line;
    logic [24:0] value;
    int          exp_addr;
    logic [24:0] exp_value;
  } vec_t;

  int rho_tb [5][5] = '{
    '{0, 1, 62, 28, 27},
    '{36, 44, 6, 55, 20},
    '{3, 10, 43, 25, 39},
    '{41, 45, 15, 21, 8},
    '{18, 2, 61, 56, 14}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every committed write must match the next expected entry.
  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {26'd0, bus.write_addr}, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("write_addr", {26'd0, bus.write_addr}, {26'd0, e.addr});
        chk("write_value", {7'd0, bus.write_value}, {7'd0, e.value});
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read_addr"}, {26'd0, bus.read_addr}, 32'd0);
    chk({tag, "_write_enable"}, {31'd0, bus.write_enable}, 32'd0);
    chk({tag, "_write_addr"}, {26'd0, bus.write_addr}, 32'd0);
    chk({tag, "_write_value"}, {7'd0, bus.write_value}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
  endtask

  // Encoder reference: rho rotates each lane, then pi moves lane (x,y) to (y, 2x+3y).
  task automatic load_encoded(input logic [24:0] plain [64]);
    logic [24:0] b [64];
    for (int z = 0; z < 64; z++) begin
      b[z] = '0;
      mem[z] = '0;
    end
    for (int z = 0; z < 64; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          b[(z + rho_tb[y][x]) % 64][5*y+x] = plain[z][5*y+x];
    for (int z = 0; z < 64; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          mem[z][5*((2*x + 3*y) % 5) + y] = b[z][5*y+x];
  endtask

  task automatic push_plain(input logic [24:0] plain [64]);
    for (int a = 0; a < 64; a++) sb.push_back({6'(a), plain[a]});
  endtask

  // One block: start edge E0, read_addr sequence, done timing, all writes seen.
  task automatic run_block(input bit hold);
    int e0;
    int k;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    e0 = cyc;
    if (!hold) bus.start = 1'b0;
    seen = 1'b0;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      k = cyc - e0;
      if (k <= 64) chk("read_addr", {26'd0, bus.read_addr}, (k > 63) ? 32'd63 : 32'(k));
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("done_cycle", 32'(k), 32'd129);
    chk("writes_left", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    vec_t vecs [7];
    logic [24:0] plain [64];
    bit found;

    vecs[0] = '{line: 0,  value: 25'h0000000, exp_addr: 0,  exp_value: 25'h0000000};
    vecs[1] = '{line: 0,  value: 25'h0000001, exp_addr: 0,  exp_value: 25'h0000001};
    vecs[2] = '{line: 0,  value: 25'h0000002, exp_addr: 20, exp_value: 25'h0000040};
    vecs[3] = '{line: 3,  value: 25'h0000001, exp_addr: 3,  exp_value: 25'h0000001};
    vecs[4] = '{line: 0,  value: 25'h0000020, exp_addr: 36, exp_value: 25'h0000008};
    vecs[5] = '{line: 10, value: 25'h1000000, exp_addr: 8,  exp_value: 25'h0200000};
    vecs[6] = '{line: 63, value: 25'h0001000, exp_addr: 38, exp_value: 25'h0002000};

    rst = 1'b1;
    bus.start = 1'b0;
    for (int z = 0; z < 64; z++) mem[z] = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single-bit encoded patterns with hand-derived decoded positions.
    for (int v = 0; v < 7; v++) begin
      for (int z = 0; z < 64; z++) mem[z] = '0;
      mem[vecs[v].line] = vecs[v].value;
      for (int a = 0; a < 64; a++)
        sb.push_back({6'(a), (a == vecs[v].exp_addr) ? vecs[v].exp_value : 25'h0});
      run_block(1'b0);
    end

    // Random plain blocks through the encoder reference.
    for (int r = 0; r < 2; r++) begin
      for (int z = 0; z < 64; z++) plain[z] = 25'($urandom());
      load_encoded(plain);
      push_plain(plain);
      run_block(1'b0);
    end

    // Reset at write address 30, then a fresh full block.
    for (int z = 0; z < 64; z++) plain[z] = 25'($urandom());
    load_encoded(plain);
    push_plain(plain);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.write_enable === 1'b1 && bus.write_addr == 6'd30) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_addr30", {31'd0, found}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midreset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int z = 0; z < 64; z++) plain[z] = 25'($urandom());
    load_encoded(plain);
    push_plain(plain);
    run_block(1'b0);

    // Start held through DONE must not retrigger.
    for (int z = 0; z < 64; z++) plain[z] = 25'($urandom());
    load_encoded(plain);
    push_plain(plain);
    run_block(1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("done_held", {31'd0, bus.done}, 32'd1);
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_falls", {31'd0, bus.done}, 32'd0);
    push_plain(plain);
    run_block(1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/matrix_decoder.md
# matrix_decoder

Decodes one 64-slice, 25-bit-per-slice matrix block back to plain form by undoing the encoder's lane permutation (pi) and lane rotation (rho). Sits on the read side of the matrix memory, mirroring the encoder's start/done framing. It reads all 64 encoded slices from a line memory, buffers the full 1600-bit state, then writes 64 decoded slices to an output memory.

## Interface
Parameters:
- none; all dimensions are fixed by `matrix_codec_pkg`.

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  level; begins a block when sampled high in IDLE
- `read_addr`  out  6  slice address presented to the encoded line memory
- `line_in`  in  25  encoded slice data; valid the cycle after `read_addr` (1-cycle memory latency)
- `write_enable`  out  1  high for each decoded slice write
- `write_addr`  out  6  decoded slice index z
- `write_value`  out  25  decoded slice z
- `done`  out  1  level; high in DONE state

Bit mapping: slice bit `5*y+x` = lane (x,y) at depth z, where slice index = z.

## Operation
- Buffer: 25 lanes × 64 bits, loaded from `line_in`. Not cleared by reset.
- Decode: with P = encoded state, R[a][b] = P[b][(2a+3b) mod 5] (inverse pi); D[x][y][z] = R[x][y][(z + r[x][y]) mod 64] (inverse rho). Index arithmetic is mod 5 and mod 64 (6-bit wrap).
- Rho offsets r[x][y], listed as x=0..4 for each y:
  - y0: 0,1,62,28,27
  - y1: 36,44,6,55,20
  - y2: 3,10,43,25,39
  - y3: 41,45,15,21,8
  - y4: 18,2,61,56,14
- FSM: IDLE → LOAD → WRITE → DONE → IDLE.
  - IDLE: outputs idle. `start`=1 → LOAD.
  - LOAD: `read_addr` counts 0..63. `line_in` is captured into slice k one cycle after address k. After the slice-63 capture → WRITE.
  - WRITE: `write_enable`=1, `write_addr` counts 0..63, `write_value`=D[*][*][write_addr]. After addr 63 → DONE.
  - DONE: `done`=1. Stays until `start`=0, then → IDLE. `start` held high never re-triggers.
- `start` changes during LOAD/WRITE are ignored; the block always completes.

## Timing
- Reset values: state IDLE, `read_addr`=0, `write_enable`=0, `write_addr`=0, `write_value`=0, `done`=0.
- E0 is the edge that samples `start`=1.
- LOAD: cycle k (after edge Ek) drives `read_addr`=k. Slice k is captured at E(k+2). The last capture is at E65, and WRITE begins then. In LOAD cycle 64, `read_addr` holds 63.
- WRITE: 64 cycles; writes commit at E66..E129.
- `done` rises after E129.
- `write_enable`, `write_addr` and `write_value` are decoded from registered state/counter only; no combinational path from `line_in` or `start`.
- Reset asserted mid-LOAD or mid-WRITE: immediately IDLE, all outputs at reset values, no further writes. The next `start` restarts from slice 0.
- Back-to-back operation: minimum one IDLE cycle between blocks (`start` must drop in DONE).

## Structure
- `matrix_codec_pkg`: `LANES`=25, `DEPTH`=64, `SLICE_W`=25, the rho offset constant array, the inverse-pi index function, and the state enum {IDLE, LOAD, WRITE, DONE}.
- Sub-module `slice_gather`: purely combinational. Takes the 1600-bit buffer and z, and returns the 25-bit decoded slice (25 × 64:1 muxes with per-lane constant offset).
- `matrix_decoder` holds the FSM, counters, buffer and output registers.

## Test plan
- All-zero memory, `start` pulsed → 64 writes of 25'h0 at addr 0..63; `done` rises after E129.
- Line 0 = 25'h0000001, rest 0 → only addr 0 written 25'h0000001; all others 0.
- Line 0 = 25'h0000002 (P[1][0], z=0), rest 0 → addr 20 = 25'h0000040 (lane (1,1)); all others 0.
- Random block encoded with the encoder's reference model → decoded output equals the original plain block, all 64 slices.
- `rst` asserted at WRITE addr 30 → `write_enable` drops the same cycle; outputs at reset values. A fresh `start` yields a full correct 64-write sequence.
- `start` held high through DONE for 20 cycles → no second LOAD. Drop `start` then raise it → new block begins; `done` falls on exit from DONE.
